// File: rtl/vga_timing_gen.sv
// Free-running XGA raster timing generator: counters, sync/blank strobes, frame pulse and frame count.
// Define VGA_TIMING_NEG_SYNC_EN to drive hsync/vsync active-low at the output flops.
module vga_timing_gen #(
    parameter int H_TOTAL       = 1344,
    parameter int H_BLANK_START = 1024,
    parameter int H_SYNC_START  = 1048,
    parameter int H_SYNC_END    = 1184,
    parameter int V_TOTAL       = 806,
    parameter int V_BLANK_START = 768,
    parameter int V_SYNC_START  = 771,
    parameter int V_SYNC_END    = 777,
    parameter int CNT_W         = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcount,
    output logic             hsync,
    output logic             hblnk,
    output logic [CNT_W-1:0] vcount,
    output logic             vsync,
    output logic             vblnk,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

`ifdef VGA_TIMING_NEG_SYNC_EN
    localparam logic SYNC_INV = 1'b1;
`else
    localparam logic SYNC_INV = 1'b0;
`endif

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_TOT  = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] V_TOT  = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] H_BS   = CNT_W'(H_BLANK_START);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_SYNC_END);
    localparam logic [CNT_W-1:0] V_BS   = CNT_W'(V_BLANK_START);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_SYNC_END);

    logic             h_wrap;
    logic             f_wrap;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;

    // Strobes are decoded from the next-state counters so they line up with the registered counts.
    always_comb begin
        h_wrap = (hcount == H_LAST);
        f_wrap = h_wrap && (vcount == V_LAST);
        h_next = h_wrap ? '0 : hcount + 1'b1;
        v_next = vcount;
        if (h_wrap)
            v_next = (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= SYNC_INV;
            vsync       <= SYNC_INV;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (en) begin
            hcount      <= h_next;
            vcount      <= v_next;
            hblnk       <= (h_next >= H_BS) && (h_next < H_TOT);
            hsync       <= ((h_next >= H_SS) && (h_next < H_SE)) ^ SYNC_INV;
            vblnk       <= (v_next >= V_BS) && (v_next < V_TOT);
            vsync       <= ((v_next >= V_SS) && (v_next < V_SE)) ^ SYNC_INV;
            frame_start <= f_wrap;
            if (f_wrap)
                frame_cnt <= frame_cnt + 8'd1;
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunk raster (16x8) so whole frames and the 256-frame wrap fit in a short run.
module tb_vga_timing_gen;

    localparam int HT = 16, HBS = 10, HSS = 12, HSE = 14;
    localparam int VT = 8,  VBS = 5,  VSS = 6,  VSE = 7;
    localparam int W  = 11;
`ifdef VGA_TIMING_NEG_SYNC_EN
    localparam logic NEG = 1'b1;
`else
    localparam logic NEG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [W-1:0] hcount, vcount;
    logic         hsync, hblnk, vsync, vblnk, frame_start;
    logic [7:0]   frame_cnt;

    vga_timing_gen #(
        .H_TOTAL(HT), .H_BLANK_START(HBS), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_TOTAL(VT), .V_BLANK_START(VBS), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
        .CNT_W(W)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .hcount(hcount), .hsync(hsync), .hblnk(hblnk),
        .vcount(vcount), .vsync(vsync), .vblnk(vblnk),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] h;
        logic [W-1:0] v;
        logic         hs, hb, vs, vb, fs;
        logic [7:0]   fc;
    } obs_t;

    // Table strobe fields are active-high; sync polarity is applied when pushed.
    typedef struct packed {
        logic       r, e;
        int         h, v;
        logic       hs, hb, vs, vb, fs;
        logic [7:0] fc;
    } vec_t;

    obs_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    int   mh = 0, mv = 0;
    int   mfc = 0;
    logic mfs = 1'b0;

    function automatic obs_t model_obs();
        obs_t o;
        o.h  = W'(mh);
        o.v  = W'(mv);
        o.hs = ((mh >= HSS) && (mh < HSE)) ^ NEG;
        o.hb = (mh >= HBS) && (mh < HT);
        o.vs = ((mv >= VSS) && (mv < VSE)) ^ NEG;
        o.vb = (mv >= VBS) && (mv < VT);
        o.fs = mfs;
        o.fc = 8'(mfc);
        return o;
    endfunction

    task automatic model_step(input logic r, input logic e);
        if (r) begin
            mh = 0; mv = 0; mfc = 0; mfs = 1'b0;
        end else if (e) begin
            mfs = (mh == HT - 1) && (mv == VT - 1);
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            if (mfs) mfc = (mfc + 1) % 256;
        end else begin
            mfs = 1'b0;
        end
    endtask

    task automatic check(input string name);
        obs_t act, exp;
        act = {hcount, vcount, hsync, hblnk, vsync, vblnk, frame_start, frame_cnt};
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            exp = q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b fc=%0d, want h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b fc=%0d",
                         name, act.h, act.v, act.hs, act.hb, act.vs, act.vb, act.fs, act.fc,
                         exp.h, exp.v, exp.hs, exp.hb, exp.vs, exp.vb, exp.fs, exp.fc);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic e, input string name);
        rst = r;
        en  = e;
        @(posedge clk);
        model_step(r, e);
        q.push_back(model_obs());
        @(negedge clk);
        check(name);
    endtask

    task automatic run_to(input int th, input int tv);
        for (int i = 0; i < HT * VT + 1; i++) begin
            if (mh == th && mv == tv) return;
            cyc(1'b0, 1'b1, "run");
        end
        chk("run_to_timeout", 0, 1);
    endtask

    initial begin
        vec_t vt[11];
        obs_t o;
        int   n, cnt_hs, cnt_hb, cnt_vs, cnt_vb, pulses, fc0;

        vt[0]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[1]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[2]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[3]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[4]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[5]  = '{1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[6]  = '{1'b0, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[7]  = '{1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[8]  = '{1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[9]  = '{1'b0, 1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[10] = '{1'b0, 1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

        // Reset value before any clock edge.
        #1;
        q.push_back(model_obs());
        check("reset_state");

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            rst = vt[i].r;
            en  = vt[i].e;
            @(posedge clk);
            model_step(vt[i].r, vt[i].e);
            o.h  = W'(vt[i].h);
            o.v  = W'(vt[i].v);
            o.hs = vt[i].hs ^ NEG;
            o.hb = vt[i].hb;
            o.vs = vt[i].vs ^ NEG;
            o.vb = vt[i].vb;
            o.fs = vt[i].fs;
            o.fc = vt[i].fc;
            q.push_back(o);
            @(negedge clk);
            check("table");
        end

        // Asynchronous reset mid-line: outputs must clear before the next edge.
        run_to(HT / 2, 1);
        rst = 1'b1;
        #1;
        model_step(1'b1, 1'b0);
        q.push_back(model_obs());
        check("async_rst");
        cyc(1'b1, 1'b1, "rst_hold");
        cyc(1'b1, 1'b1, "rst_hold");

        // First frame_start after release arrives after exactly HT*VT enabled edges.
        n = 0;
        for (int i = 0; i < 3 * HT * VT; i++) begin
            cyc(1'b0, 1'b1, "first_frame");
            n++;
            if (frame_start) break;
        end
        chk("first_frame_len", n, HT * VT);
        chk("first_frame_cnt", int'(frame_cnt), 1);

        // One full frame from (0,0): strobe widths.
        cnt_hs = 0; cnt_hb = 0; cnt_vs = 0; cnt_vb = 0;
        for (int i = 0; i < HT * VT; i++) begin
            if (hsync ^ NEG) cnt_hs++;
            if (hblnk)       cnt_hb++;
            if (vsync ^ NEG) cnt_vs++;
            if (vblnk)       cnt_vb++;
            cyc(1'b0, 1'b1, "frame");
        end
        chk("hsync_width", cnt_hs, (HSE - HSS) * VT);
        chk("hblnk_width", cnt_hb, (HT - HBS) * VT);
        chk("vsync_width", cnt_vs, (VSE - VSS) * HT);
        chk("vblnk_width", cnt_vb, (VT - VBS) * HT);

        // Enable hold at the last raster position.
        run_to(HT - 1, VT - 1);
        fc0 = mfc;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, "hold");
            chk("hold_no_fs", int'(frame_start), 0);
        end
        cyc(1'b0, 1'b1, "hold_release");
        chk("hold_fs", int'(frame_start), 1);
        chk("hold_fc", int'(frame_cnt), (fc0 + 1) % 256);
        cyc(1'b0, 1'b1, "hold_after");
        chk("hold_fs_single", int'(frame_start), 0);

        // 256 frames: counter wraps back, one pulse per frame.
        fc0 = mfc;
        pulses = 0;
        for (int i = 0; i < 256 * HT * VT; i++) begin
            cyc(1'b0, 1'b1, "wrap");
            if (frame_start) pulses++;
        end
        chk("wrap_pulses", pulses, 256);
        chk("wrap_fc", int'(frame_cnt), fc0);

        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
